// File: rtl/bcd_result_display.sv
// Captures a 3-digit BCD add/sub result, converts negative 10's-complement results
// to magnitude, and drives a 4-digit multiplexed 7-segment display. Macro BCD_DISP_LZB_EN enables leading-zero blanking.
module bcd_result_display #(
  parameter int SCAN_DIV = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [11:0] bcd_r,
  input  logic        kout,
  input  logic        mode,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        busy,
  output logic        err,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, CONV = 2'd1, SHOW = 2'd2} state_t;

  localparam logic [1:0] SGN_BLANK = 2'd0;
  localparam logic [1:0] SGN_ONE   = 2'd1;
  localparam logic [1:0] SGN_MINUS = 2'd2;
  localparam logic [6:0] GLYPH_E   = 7'b1111001;

  // Handshake: load is a single-cycle request, accepted on any rising edge
  // outside CONV; busy is high exactly while a conversion is in flight.

  state_t      state, state_nxt;
  logic [15:0] pre_cnt;
  logic [1:0]  scan_idx;
  logic [3:0]  w_d0, w_d1, w_d2;
  logic [1:0]  step;
  logic        carry;
  logic [3:0]  dd0, dd1, dd2;
  logic [1:0]  dsign;
  logic        derr, dvalid;
  logic        bad, neg;
  logic [3:0]  cur_d, conv_d;
  logic [4:0]  t_sum;
  logic        conv_c;
  logic        blank1, blank2;
  logic [6:0]  dig_seg;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0: glyph = 7'b0111111;
      4'd1: glyph = 7'b0000110;
      4'd2: glyph = 7'b1011011;
      4'd3: glyph = 7'b1001111;
      4'd4: glyph = 7'b1100110;
      4'd5: glyph = 7'b1101101;
      4'd6: glyph = 7'b1111101;
      4'd7: glyph = 7'b0000111;
      4'd8: glyph = 7'b1111111;
      4'd9: glyph = 7'b1101111;
      default: glyph = 7'b0000000;
    endcase
  endfunction

  assign bad = (bcd_r[11:8] > 4'd9) || (bcd_r[7:4] > 4'd9) || (bcd_r[3:0] > 4'd9);
  assign neg = mode & ~kout;
  assign busy = (state == CONV);
  assign state_dbg = state;

  // One complement digit per CONV cycle, units first; carry ripples upward.
  always_comb begin
    cur_d = w_d2;
    if (step == 2'd0) cur_d = w_d0;
    else if (step == 2'd1) cur_d = w_d1;
    t_sum = 5'd9 - {1'b0, cur_d} + {4'b0000, carry};
    conv_c = (t_sum == 5'd10);
    conv_d = conv_c ? 4'd0 : t_sum[3:0];
  end

`ifdef BCD_DISP_LZB_EN
  assign blank2 = (dd2 == 4'd0);
  assign blank1 = (dd2 == 4'd0) && (dd1 == 4'd0);
`else
  assign blank2 = 1'b0;
  assign blank1 = 1'b0;
`endif

  always_comb begin
    dig_seg = 7'b0000000;
    case (scan_idx)
      2'd0: dig_seg = glyph(dd0);
      2'd1: dig_seg = blank1 ? 7'b0000000 : glyph(dd1);
      2'd2: dig_seg = blank2 ? 7'b0000000 : glyph(dd2);
      default: begin
        if (dsign == SGN_ONE) dig_seg = 7'b0000110;
        else if (dsign == SGN_MINUS) dig_seg = 7'b1000000;
      end
    endcase
    if (derr) dig_seg = GLYPH_E;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    an = 4'b1111;
    seg = 7'b0000000;
    case (state)
      IDLE: begin
        if (load) state_nxt = (bad || !neg) ? SHOW : CONV;
      end
      CONV: begin
        if (step == 2'd2) state_nxt = SHOW;
        // Keep the previous result on the digits while converting.
        if (dvalid) begin
          an = ~(4'b0001 << scan_idx);
          seg = dig_seg;
        end
      end
      SHOW: begin
        if (load) state_nxt = (bad || !neg) ? SHOW : CONV;
        an = ~(4'b0001 << scan_idx);
        seg = dig_seg;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt  <= 16'd0;
      scan_idx <= 2'd0;
    end else if (pre_cnt == 16'(SCAN_DIV - 1)) begin
      pre_cnt  <= 16'd0;
      scan_idx <= scan_idx + 2'd1;
    end else begin
      pre_cnt <= pre_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_d0 <= 4'd0; w_d1 <= 4'd0; w_d2 <= 4'd0;
      step <= 2'd0; carry <= 1'b0;
      dd0 <= 4'd0; dd1 <= 4'd0; dd2 <= 4'd0;
      dsign <= SGN_BLANK; derr <= 1'b0; dvalid <= 1'b0; err <= 1'b0;
    end else if (state == CONV) begin
      step  <= step + 2'd1;
      carry <= conv_c;
      case (step)
        2'd0: w_d0 <= conv_d;
        2'd1: w_d1 <= conv_d;
        default: begin
          dd0    <= w_d0;
          dd1    <= w_d1;
          dd2    <= conv_d;
          dsign  <= ({conv_d, w_d1, w_d0} == 12'h000) ? SGN_BLANK : SGN_MINUS;
          derr   <= 1'b0;
          dvalid <= 1'b1;
        end
      endcase
    end else if (load) begin
      if (bad) begin
        err    <= 1'b1;
        derr   <= 1'b1;
        dvalid <= 1'b1;
      end else if (neg) begin
        err   <= 1'b0;
        w_d2  <= bcd_r[11:8];
        w_d1  <= bcd_r[7:4];
        w_d0  <= bcd_r[3:0];
        step  <= 2'd0;
        carry <= 1'b1;
      end else begin
        err    <= 1'b0;
        dd2    <= bcd_r[11:8];
        dd1    <= bcd_r[7:4];
        dd0    <= bcd_r[3:0];
        dsign  <= (!mode && kout) ? SGN_ONE : SGN_BLANK;
        derr   <= 1'b0;
        dvalid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bcd_result_display.sv
// Randomized bench for bcd_result_display against a decimal-arithmetic reference model.
module tb_bcd_result_display;

  localparam int SCAN_DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n, load, kout, mode;
  logic [11:0] bcd_r;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        busy, err;
  logic [1:0]  state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: 0 idle, 1 converting, 2 showing; displayed value kept as an integer.
  int m_state, m_conv_left, m_pending, m_edges, m_mag, m_sign;
  bit m_have, m_edisp, m_err;

  bcd_result_display #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .bcd_r(bcd_r), .kout(kout), .mode(mode),
    .seg(seg), .an(an), .busy(busy), .err(err), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] ref_glyph(input int d);
    case (d)
      0: return 7'b0111111;
      1: return 7'b0000110;
      2: return 7'b1011011;
      3: return 7'b1001111;
      4: return 7'b1100110;
      5: return 7'b1101101;
      6: return 7'b1111101;
      7: return 7'b0000111;
      8: return 7'b1111111;
      9: return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic logic [6:0] exp_digit(input int idx);
    if (m_edisp) return 7'b1111001;
    if (idx == 3) begin
      if (m_sign == 1) return 7'b0000110;
      if (m_sign == 2) return 7'b1000000;
      return 7'b0000000;
    end
`ifdef BCD_DISP_LZB_EN
    if (idx == 2 && m_mag < 100) return 7'b0000000;
    if (idx == 1 && m_mag < 10) return 7'b0000000;
`endif
    if (idx == 2) return ref_glyph(m_mag / 100);
    if (idx == 1) return ref_glyph((m_mag / 10) % 10);
    return ref_glyph(m_mag % 10);
  endfunction

  task automatic model_reset();
    m_state = 0; m_conv_left = 0; m_pending = 0; m_edges = 0;
    m_mag = 0; m_sign = 0; m_have = 0; m_edisp = 0; m_err = 0;
  endtask

  task automatic model_edge();
    int h, t, u, v;
    m_edges++;
    if (m_state != 1 && load) begin
      h = int'(bcd_r[11:8]); t = int'(bcd_r[7:4]); u = int'(bcd_r[3:0]);
      if (h > 9 || t > 9 || u > 9) begin
        m_err = 1; m_edisp = 1; m_have = 1; m_state = 2;
      end else begin
        v = 100 * h + 10 * t + u;
        m_err = 0;
        if (mode && !kout) begin
          m_pending = v; m_conv_left = 3; m_state = 1;
        end else begin
          m_mag = v; m_sign = (!mode && kout) ? 1 : 0;
          m_edisp = 0; m_have = 1; m_state = 2;
        end
      end
    end else if (m_state == 1) begin
      m_conv_left--;
      if (m_conv_left == 0) begin
        m_mag = (1000 - m_pending) % 1000;
        m_sign = (m_mag == 0) ? 0 : 2;
        m_edisp = 0; m_have = 1; m_state = 2;
      end
    end
  endtask

  task automatic compare_all();
    int idx;
    bit lit;
    logic [3:0] one_hot, exp_an;
    logic [6:0] exp_seg;
    idx = (m_edges / SCAN_DIV) % 4;
    lit = (m_state == 2) || (m_state == 1 && m_have);
    one_hot = 4'b0001 << idx;
    exp_an = lit ? ~one_hot : 4'b1111;
    exp_seg = lit ? exp_digit(idx) : 7'b0000000;
    check("an", 32'(an), 32'(exp_an));
    check("seg", 32'(seg), 32'(exp_seg));
    check("busy", 32'(busy), 32'(m_state == 1));
    check("err", 32'(err), 32'(m_err));
    check("state", 32'(state_dbg), 32'(m_state));
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic do_load(input logic [11:0] v, input logic k, input logic m);
    load = 1'b1; bcd_r = v; kout = k; mode = m;
    cycle();
    load = 1'b0;
  endtask

  initial begin
    logic [11:0] v;
    rst_n = 1'b0; load = 1'b0; bcd_r = 12'h000; kout = 1'b0; mode = 1'b0;
    model_reset();
    #1 compare_all();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(20);

    do_load(12'h998, 1'b1, 1'b0); idle(20);
    do_load(12'h771, 1'b0, 1'b1); idle(20);
    do_load(12'h057, 1'b1, 1'b1); idle(16);
    do_load(12'h5A3, 1'b0, 1'b0); idle(16);
    do_load(12'h000, 1'b1, 1'b1); idle(16);
    do_load(12'h000, 1'b0, 1'b1); idle(16);
    do_load(12'h999, 1'b0, 1'b1); idle(16);

    // Second request while converting must be dropped.
    do_load(12'h771, 1'b0, 1'b1);
    do_load(12'h123, 1'b1, 1'b0);
    idle(20);

    // Asynchronous reset in the middle of a conversion.
    do_load(12'h771, 1'b0, 1'b1);
    cycle();
    #2 rst_n = 1'b0;
    #1 model_reset();
    compare_all();
    cycle(); cycle();
    rst_n = 1'b1;
    idle(12);
    do_load(12'h456, 1'b0, 1'b1); idle(12);

    repeat (600) begin
      if ($urandom_range(0, 4) == 0) begin
        v = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
        if ($urandom_range(0, 7) == 0) v[4 * $urandom_range(0, 2) +: 4] = 4'($urandom_range(10, 15));
        do_load(v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else begin
        cycle();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/bcd_result_display.md
BCD_RESULT_DISPLAY -- requirements
Module: bcd_result_display

Interface
REQ-001 Parameter SCAN_DIV, default 4, clock cycles each digit stays enabled; legal range 2..65535.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 load  input  1  single-cycle request to capture a new result.
REQ-005 bcd_r  input  12  3-digit BCD result from the add/sub stage; [11:8] hundreds, [3:0] units.
REQ-006 kout  input  1  carry/sign flag from the add/sub stage.
REQ-007 mode  input  1  0 = result of an addition, 1 = result of a subtraction.
REQ-008 seg  output  7  segments {g,f,e,d,c,b,a}, active-high.
REQ-009 an  output  4  digit enables, active-low one-hot; an[0] = units, an[3] = sign/carry digit.
REQ-010 busy  output  1  high while a capture or conversion is in progress.
REQ-011 err  output  1  high while the displayed value came from an invalid BCD nibble.

Function
REQ-012 The FSM SHALL have states IDLE, CONV and SHOW; reset enters IDLE.
REQ-013 In IDLE or SHOW, load=1 SHALL capture bcd_r/kout/mode on that edge; in CONV, load SHALL be ignored.
REQ-014 Any captured nibble >9 SHALL set err=1, skip CONV, enter SHOW, and display 'E' on all four digits.
REQ-015 mode=1 with kout=0 SHALL be treated as a negative result in 10's complement: enter CONV, busy=1.
REQ-016 All other valid captures SHALL enter SHOW on the next edge, with busy=0 (capture-to-display latency 1 cycle).
REQ-017 CONV SHALL last exactly 3 cycles, processing one digit per cycle from units to hundreds.
REQ-018 CONV digit step: t = (9 - d) + c, with c = 1 before units; if t = 10, output 0 and set c = 1, else output t and set c = 0.
REQ-019 After the third CONV cycle, the FSM SHALL enter SHOW with busy=0, holding the magnitude (1000 - bcd_r).
REQ-020 Digit 3: addition with kout=1 shows '1'; negative subtraction shows '-' (g only); otherwise blank.
REQ-021 A negative result whose magnitude is 000 SHALL show a blank sign digit.
REQ-022 Digits 2..0 SHALL show BCD glyphs; digit 0 is never blanked.
REQ-023 Prescaler counts 0..SCAN_DIV-1; at terminal count it wraps to 0 and the scan index advances 0→1→2→3→0.
REQ-024 In SHOW, an = ~(1 << index) and seg = glyph of that digit; blank glyph = 7'b0000000.
REQ-025 In IDLE, an = 4'b1111 and seg = 0.
REQ-026 In CONV, an and seg SHALL keep the previous SHOW content, or stay off if no previous SHOW exists.
REQ-027 Prescaler and scan index SHALL run free in every state and SHALL NOT reset on load.
REQ-028 err SHALL clear on the next accepted valid load.
REQ-029 Glyphs: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111, E=1111001.

Reset
REQ-030 rst_n=0 SHALL immediately force state IDLE and clear all of the following: stored digits, sign, prescaler, scan index, carry, busy, and err.
REQ-031 While rst_n=0, an SHALL be 4'b1111 and seg SHALL be 0.
REQ-032 Reset asserted mid-CONV SHALL abort the conversion; no partial value SHALL be displayed after release.
REQ-033 After rst_n rises, the first accepted load SHALL behave exactly as in REQ-013..REQ-019.

Configuration
REQ-034 Macro BCD_DISP_LZB_EN SHALL compile leading-zero blanking in or out.
REQ-035 With BCD_DISP_LZB_EN defined, digit 2 blanks when it is 0, and digit 1 blanks when both digit 2 and digit 1 are 0.
REQ-036 With BCD_DISP_LZB_EN defined, the sign digit is unaffected by blanking.
REQ-037 With BCD_DISP_LZB_EN undefined, digits 2..0 SHALL always show their glyph.

Verification (SCAN_DIV=4)
REQ-038 Reset, then idle 20 cycles -> an=1111, seg=0, busy=0, err=0.
REQ-039 load with bcd_r=0x998, kout=1, mode=0 -> one cycle later SHOW; across scan: an=0111 shows '1', then '9','9','8'; each digit held 4 cycles.
REQ-040 load with bcd_r=0x771, kout=0, mode=1 -> busy=1 for exactly 3 cycles, then display '-','2','2','9'.
REQ-041 load with bcd_r=0x057, kout=1, mode=1 -> sign blank; hundreds glyph 0 without BCD_DISP_LZB_EN, blank with it.
REQ-042 load with bcd_r=0x5A3 -> err=1 and 'E' on all digits; a following valid load of 0x000, kout=1, mode=1 -> err=0, display blank,'0','0','0' (without BCD_DISP_LZB_EN).
REQ-043 Second load during CONV -> ignored, 229 displayed; rst_n pulsed low mid-CONV -> an=1111 immediately and state IDLE after release.
